r_fifo_sync: RTL and testbench

Address/enable controller that sits between the router input FSM and the three output FIFOs. Latches the destination address from each packet header and steers write enables to exactly one FIFO. Reports that FIFO's full status upstream and drives per-port valid flags. Runs a per-FIFO read-timeout that pulses the FIFO's `soft_rst` when a destination leaves a non-empty FIFO unread for `TIMEOUT` cycles.

---
 rtl/r_router_pkg.sv | 11 +
 rtl/r_fifo_timeout.sv | 36 +++
 rtl/r_fifo_sync.sv | 55 +++++
 tb/tb_r_fifo_sync.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/r_router_pkg.sv
// Shared router constants and types for the FIFO-side address/enable controller.
package r_router_pkg;
  localparam int NUM_FIFO = 3;
  localparam int ADDR_W   = 2;
  localparam int TIMEOUT  = 30;
  localparam int CNT_W    = 5;

  localparam logic [ADDR_W-1:0] INVALID_ADDR = '1;

  typedef logic [NUM_FIFO-1:0] fifo_vec_t;
endpackage

// File: rtl/r_fifo_timeout.sv
// Per-FIFO read timeout: counts cycles a FIFO holds data unread and emits
// a one-cycle soft reset once TIMEOUT consecutive idle cycles have elapsed.
module r_fifo_timeout #(
  parameter int TIMEOUT = r_router_pkg::TIMEOUT,
  parameter int CNT_W   = r_router_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic rd,
  output logic soft_rst
);
  logic [CNT_W-1:0] cnt;
  logic             inc;

  // The pulse cycle itself is excluded so back-to-back pulses are TIMEOUT+1 apart.
  assign inc = vld & ~rd & ~soft_rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      soft_rst <= 1'b0;
    end else if (rd || !vld) begin
      cnt      <= '0;
      soft_rst <= 1'b0;
    end else if (inc && cnt == CNT_W'(TIMEOUT - 1)) begin
      cnt      <= '0;
      soft_rst <= 1'b1;
    end else if (inc) begin
      cnt      <= cnt + 1'b1;
      soft_rst <= 1'b0;
    end else begin
      soft_rst <= 1'b0;
    end
  end
endmodule

// File: rtl/r_fifo_sync.sv
// Router FIFO controller: latches header address, steers one-hot write enables,
// muxes the addressed FIFO's full flag and runs per-FIFO read timeouts.
module r_fifo_sync #(
  parameter int NUM_FIFO = r_router_pkg::NUM_FIFO,
  parameter int ADDR_W   = r_router_pkg::ADDR_W,
  parameter int TIMEOUT  = r_router_pkg::TIMEOUT,
  parameter int CNT_W    = r_router_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                detect_add,
  input  logic [ADDR_W-1:0]   din_addr,
  input  logic                write_enb_reg,
  input  logic [NUM_FIFO-1:0] empty,
  input  logic [NUM_FIFO-1:0] full,
  input  logic [NUM_FIFO-1:0] read_enb,
  output logic [NUM_FIFO-1:0] write_enb,
  output logic                fifo_full,
  output logic [NUM_FIFO-1:0] vld_out,
  output logic [NUM_FIFO-1:0] soft_rst
);
  logic [ADDR_W-1:0] addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             addr <= ADDR_W'(r_router_pkg::INVALID_ADDR);
    else if (detect_add) addr <= din_addr;
  end

  // Matching only indices below NUM_FIFO makes out-of-range addresses drop silently.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_FIFO; i++) begin
      if (addr == ADDR_W'(i)) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  assign vld_out = ~empty;

  for (genvar g = 0; g < NUM_FIFO; g++) begin : g_to
    r_fifo_timeout #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_to (
      .clk      (clk),
      .rst      (rst),
      .vld      (vld_out[g]),
      .rd       (read_enb[g]),
      .soft_rst (soft_rst[g])
    );
  end
endmodule

// File: tb/tb_r_fifo_sync.sv
// Directed scoreboard bench for r_fifo_sync: stimulus queues expected outputs
// per cycle, a negedge monitor pops and compares against the DUT.
module tb_r_fifo_sync;
  logic       clk = 1'b0;
  logic       rst;
  logic       detect_add;
  logic [1:0] din_addr;
  logic       write_enb_reg;
  logic [2:0] empty, full, read_enb;
  logic [2:0] write_enb, vld_out, soft_rst;
  logic       fifo_full;

  typedef struct {
    string      name;
    logic [2:0] we;
    logic       ff;
    logic [2:0] vld;
    logic [2:0] sr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  r_fifo_sync dut (
    .clk           (clk),
    .rst           (rst),
    .detect_add    (detect_add),
    .din_addr      (din_addr),
    .write_enb_reg (write_enb_reg),
    .empty         (empty),
    .full          (full),
    .read_enb      (read_enb),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .vld_out       (vld_out),
    .soft_rst      (soft_rst)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (write_enb === e.we && fifo_full === e.ff && vld_out === e.vld && soft_rst === e.sr)
        passed++;
      else
        $display("FAIL %s: got we=%b ff=%b vld=%b sr=%b, want we=%b ff=%b vld=%b sr=%b",
                 e.name, write_enb, fifo_full, vld_out, soft_rst, e.we, e.ff, e.vld, e.sr);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string n, input logic [2:0] we, input logic ff,
                            input logic [2:0] vld, input logic [2:0] sr);
    exp_t e;
    e.name = n; e.we = we; e.ff = ff; e.vld = vld; e.sr = sr;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; detect_add = 1'b0; din_addr = 2'b00; write_enb_reg = 1'b0;
    empty = 3'b111; full = 3'b000; read_enb = 3'b000;
    #1;
    expect_now("reset_state", 3'b000, 1'b0, 3'b000, 3'b000);
    next_cycle(); next_cycle();
    rst = 1'b0;

    // Write request before any header: address is still invalid.
    next_cycle();
    write_enb_reg = 1'b1; full = 3'b111;
    expect_now("no_header_write", 3'b000, 1'b0, 3'b000, 3'b000);

    // Steering to FIFO 1.
    next_cycle();
    write_enb_reg = 1'b0; full = 3'b000;
    detect_add = 1'b1; din_addr = 2'b01;
    expect_now("hdr_cycle_old_addr", 3'b000, 1'b0, 3'b000, 3'b000);
    next_cycle();
    detect_add = 1'b0; write_enb_reg = 1'b1;
    for (int k = 0; k < 16; k++) begin
      expect_now("steer_addr1", 3'b010, 1'b0, 3'b000, 3'b000);
      if (k != 15) next_cycle();
    end
    next_cycle();
    full = 3'b010;
    expect_now("full_addressed", 3'b010, 1'b1, 3'b000, 3'b000);
    next_cycle();
    full = 3'b100;
    expect_now("full_other", 3'b010, 1'b0, 3'b000, 3'b000);

    // Invalid address 11 drops the packet.
    next_cycle();
    write_enb_reg = 1'b0; detect_add = 1'b1; din_addr = 2'b11; full = 3'b111;
    expect_now("hdr_invalid", 3'b000, 1'b1, 3'b000, 3'b000);
    next_cycle();
    detect_add = 1'b0; write_enb_reg = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_now("invalid_addr", 3'b000, 1'b0, 3'b000, 3'b000);
      next_cycle();
    end
    write_enb_reg = 1'b0; full = 3'b000;

    // Same-cycle header and write: old address 00 decodes, then 10.
    detect_add = 1'b1; din_addr = 2'b00;
    expect_now("hdr_addr0", 3'b000, 1'b0, 3'b000, 3'b000);
    next_cycle();
    detect_add = 1'b1; din_addr = 2'b10; write_enb_reg = 1'b1;
    expect_now("simul_old", 3'b001, 1'b0, 3'b000, 3'b000);
    next_cycle();
    detect_add = 1'b0;
    expect_now("simul_new", 3'b100, 1'b0, 3'b000, 3'b000);
    next_cycle();
    write_enb_reg = 1'b0;

    // Timeout on FIFO 0: pulses at k=30 and k=61.
    empty = 3'b110;
    for (int k = 0; k <= 63; k++) begin
      expect_now("timeout0", 3'b000, 1'b0, 3'b001,
                 (k == 30 || k == 61) ? 3'b001 : 3'b000);
      next_cycle();
    end
    empty = 3'b111;
    expect_now("timeout0_drained", 3'b000, 1'b0, 3'b000, 3'b000);
    next_cycle();

    // FIFO 2 restart: read at k=29 suppresses the pulse, next at k=60.
    empty = 3'b011;
    for (int k = 0; k <= 62; k++) begin
      read_enb = (k == 29) ? 3'b100 : 3'b000;
      expect_now("timeout2_restart", 3'b000, 1'b0, 3'b100,
                 (k == 60) ? 3'b100 : 3'b000);
      next_cycle();
    end
    read_enb = 3'b000; empty = 3'b111;

    // Asynchronous reset mid-packet and mid-count.
    detect_add = 1'b1; din_addr = 2'b01;
    next_cycle();
    detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b010; empty = 3'b101;
    for (int k = 0; k < 10; k++) begin
      expect_now("pre_reset", 3'b010, 1'b1, 3'b010, 3'b000);
      next_cycle();
    end
    rst = 1'b1;
    expect_now("mid_reset", 3'b000, 1'b0, 3'b010, 3'b000);
    next_cycle();
    expect_now("held_reset", 3'b000, 1'b0, 3'b010, 3'b000);
    next_cycle();
    rst = 1'b0; empty = 3'b111;
    expect_now("post_reset_write", 3'b000, 1'b0, 3'b000, 3'b000);
    next_cycle();
    write_enb_reg = 1'b0;

    for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
